// File: rtl/csr_reg_file_pkg.sv
// Shared constants for the machine-mode CSR block: addresses, mstatus fields,
// trap cause codes, XLEN encodings and the trap FSM state type.
package csr_reg_file_pkg;

  localparam int XLEN_32B = 1;
  localparam int XLEN_64B = 2;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  localparam int MCAUSE_ECALL = 11;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam logic [1:0] MSTATUS_MPP_M = 2'b11;

  typedef enum logic {S_RUN, S_HANDLER} trap_state_e;

  function automatic int xlen_width(input int xlen);
    return 1 << (xlen + 4);
  endfunction

endpackage

// File: rtl/csr_reg_file_trap_fsm.sv
// Trap sequencer: tracks whether a handler is running and selects the
// redirect target for ecall (mtvec) and mret (mepc). ecall outranks mret.
//
// state     | meaning
// S_RUN     | normal execution, no trap handler active
// S_HANDLER | an ecall has been taken, handler running until mret
module csr_reg_file_trap_fsm
  import csr_reg_file_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_ecall,
  input  logic         i_mret,
  input  logic [W-1:0] i_mtvec,
  input  logic [W-1:0] i_mepc,
  output logic         o_take_trap,
  output logic         o_take_mret,
  output logic         o_redirect,
  output logic [W-1:0] o_redirect_pc,
  output logic         o_in_handler
);

  trap_state_e r_state;
  trap_state_e w_state_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_take_trap   = 1'b0;
    o_take_mret   = 1'b0;
    o_redirect    = 1'b0;
    o_redirect_pc = '0;
    if (i_ecall) begin
      w_state_nxt   = S_HANDLER;
      o_take_trap   = 1'b1;
      o_redirect    = 1'b1;
      o_redirect_pc = i_mtvec;
    end else if (i_mret) begin
      w_state_nxt   = S_RUN;
      o_take_mret   = 1'b1;
      o_redirect    = 1'b1;
      o_redirect_pc = i_mepc;
    end
  end

  assign o_in_handler = (r_state == S_HANDLER);

endmodule

// File: rtl/csr_reg_file.sv
// Machine-mode CSR storage with writeback bypass and trap field updates.
// Define CSR_COUNTERS_EN to add the mcycle/minstret counters.
module csr_reg_file
  import csr_reg_file_pkg::*;
#(
  parameter int          XLEN        = XLEN_64B,
  parameter logic [63:0] RESET_MTVEC = '0,
  localparam int         W           = xlen_width(XLEN)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [11:0]  i_csr_addr_d,
  output logic [W-1:0] o_csr_data_d,
  input  logic         i_csr_reg_write_w,
  input  logic [11:0]  i_csr_rd_w,
  input  logic [W-1:0] i_new_csr_w,
  input  logic         i_instr_retired_w,
  input  logic         i_ecall_e,
  input  logic         i_mret_e,
  input  logic [W-1:0] i_pc_e,
  output logic         o_redirect_e,
  output logic [W-1:0] o_redirect_pc_e,
  output logic         o_in_handler
);

  localparam logic [W-1:0] RESET_MTVEC_W = W'(RESET_MTVEC) & ~W'(3);

  // Value a write to address a would actually store (read-only/zero bits applied).
  function automatic logic [W-1:0] wr_mask(input logic [11:0] a, input logic [W-1:0] v);
    logic [W-1:0] m;
    m = '0;
    case (a)
      CSR_MSTATUS: begin
        m[12:11]         = MSTATUS_MPP_M;
        m[MSTATUS_MPIE] = v[MSTATUS_MPIE];
        m[MSTATUS_MIE]  = v[MSTATUS_MIE];
      end
      CSR_MTVEC, CSR_MEPC: m = {v[W-1:2], 2'b00};
      CSR_MIE, CSR_MSCRATCH, CSR_MCAUSE, CSR_MTVAL: m = v;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE, CSR_MINSTRET: m = v;
`endif
      default: m = '0;
    endcase
    return m;
  endfunction

  logic         r_mstatus_mie, r_mstatus_mpie;
  logic [W-1:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
`ifdef CSR_COUNTERS_EN
  logic [W-1:0] r_mcycle, r_minstret;
`endif

  logic [W-1:0] w_wb_val, w_mstatus, w_mtvec_eff, w_mepc_eff, w_rd_val;
  logic         w_wr_mstatus, w_mie_wb, w_mpie_wb, w_take_trap, w_take_mret;

  assign w_wb_val     = wr_mask(i_csr_rd_w, i_new_csr_w);
  assign w_wr_mstatus = i_csr_reg_write_w && (i_csr_rd_w == CSR_MSTATUS);
  assign w_mie_wb     = w_wr_mstatus ? i_new_csr_w[MSTATUS_MIE]  : r_mstatus_mie;
  assign w_mpie_wb    = w_wr_mstatus ? i_new_csr_w[MSTATUS_MPIE] : r_mstatus_mpie;
  assign w_mtvec_eff  = (i_csr_reg_write_w && i_csr_rd_w == CSR_MTVEC) ? w_wb_val : r_mtvec;
  assign w_mepc_eff   = (i_csr_reg_write_w && i_csr_rd_w == CSR_MEPC)  ? w_wb_val : r_mepc;

  always_comb begin
    w_mstatus                = '0;
    w_mstatus[12:11]         = MSTATUS_MPP_M;
    w_mstatus[MSTATUS_MPIE] = r_mstatus_mpie;
    w_mstatus[MSTATUS_MIE]  = r_mstatus_mie;
  end

  always_comb begin
    w_rd_val = '0;
    case (i_csr_addr_d)
      CSR_MSTATUS:  w_rd_val = w_mstatus;
      CSR_MIE:      w_rd_val = r_mie;
      CSR_MTVEC:    w_rd_val = r_mtvec;
      CSR_MSCRATCH: w_rd_val = r_mscratch;
      CSR_MEPC:     w_rd_val = r_mepc;
      CSR_MCAUSE:   w_rd_val = r_mcause;
      CSR_MTVAL:    w_rd_val = r_mtval;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:   w_rd_val = r_mcycle;
      CSR_MINSTRET: w_rd_val = r_minstret;
`endif
      default:      w_rd_val = '0;
    endcase
    if (i_csr_reg_write_w && (i_csr_rd_w == i_csr_addr_d))
      w_rd_val = wr_mask(i_csr_addr_d, i_new_csr_w);
  end

  assign o_csr_data_d = w_rd_val;

  // WB write lands first; trap/mret then override only the fields they own.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= RESET_MTVEC_W;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
    end else begin
      r_mstatus_mie  <= w_mie_wb;
      r_mstatus_mpie <= w_mpie_wb;
      if (i_csr_reg_write_w) begin
        case (i_csr_rd_w)
          CSR_MIE:      r_mie      <= w_wb_val;
          CSR_MTVEC:    r_mtvec    <= w_wb_val;
          CSR_MSCRATCH: r_mscratch <= w_wb_val;
          CSR_MEPC:     r_mepc     <= w_wb_val;
          CSR_MCAUSE:   r_mcause   <= w_wb_val;
          CSR_MTVAL:    r_mtval    <= w_wb_val;
          default: ;
        endcase
      end
      if (w_take_trap) begin
        r_mepc         <= {i_pc_e[W-1:2], 2'b00};
        r_mcause       <= W'(MCAUSE_ECALL);
        r_mtval        <= '0;
        r_mstatus_mpie <= w_mie_wb;
        r_mstatus_mie  <= 1'b0;
      end else if (w_take_mret) begin
        r_mstatus_mie  <= w_mpie_wb;
        r_mstatus_mpie <= 1'b1;
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (i_csr_reg_write_w && i_csr_rd_w == CSR_MCYCLE) r_mcycle <= w_wb_val;
      else                                               r_mcycle <= r_mcycle + 1'b1;
      if (i_csr_reg_write_w && i_csr_rd_w == CSR_MINSTRET) r_minstret <= w_wb_val;
      else if (i_instr_retired_w)                          r_minstret <= r_minstret + 1'b1;
    end
  end
`else
  logic w_unused_retire;
  assign w_unused_retire = i_instr_retired_w;
`endif

  csr_reg_file_trap_fsm #(.W(W)) u_trap_fsm (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_ecall       (i_ecall_e),
    .i_mret        (i_mret_e),
    .i_mtvec       (w_mtvec_eff),
    .i_mepc        (w_mepc_eff),
    .o_take_trap   (w_take_trap),
    .o_take_mret   (w_take_mret),
    .o_redirect    (o_redirect_e),
    .o_redirect_pc (o_redirect_pc_e),
    .o_in_handler  (o_in_handler)
  );

endmodule
